// File: rtl/display_capture_pkg.sv
// display_pkg: character codes, register offsets and the capture filter for the Apple-1 display port
package display_pkg;
  localparam logic [6:0] CHAR_CR    = 7'h0D;
  localparam logic [6:0] CHAR_LF    = 7'h0A;
  localparam logic [6:0] CHAR_DEL   = 7'h7F;
  localparam logic [6:0] CHAR_SPACE = 7'h20;
  localparam logic DSP_OFS   = 1'b0;
  localparam logic DSPCR_OFS = 1'b1;
  // {keep, byte}: CR becomes LF, other controls and DEL are dropped
  function automatic logic [7:0] filter_char(input logic [6:0] c);
    return (c == CHAR_CR) ? {1'b1, CHAR_LF} :
           (c < CHAR_SPACE || c == CHAR_DEL) ? 8'h00 : {1'b1, c};
  endfunction
endpackage

// File: rtl/display_capture_if.sv
// display_capture_if: CPU register bus plus host upload/clear signals of the display capture
interface display_capture_if #(parameter int DEPTH_LOG2 = 13) ();
  logic                  enable;
  logic                  cs;
  logic                  address;
  logic                  w_en;
  logic [7:0]            din;
  logic [7:0]            dout;
  logic                  clear;
  logic                  ioctl_upload;
  logic [DEPTH_LOG2-1:0] upload_addr;
  logic [7:0]            upload_dout;
  logic [DEPTH_LOG2:0]   capture_len;
  logic                  overrun;
  modport master (
    output enable, cs, address, w_en, din, clear, ioctl_upload, upload_addr,
    input  dout, upload_dout, capture_len, overrun
  );
  modport slave (
    input  enable, cs, address, w_en, din, clear, ioctl_upload, upload_addr,
    output dout, upload_dout, capture_len, overrun
  );
endinterface

// File: rtl/display_capture_ram.sv
// capture_ram: simple dual-port byte RAM, CPU write port and registered read-before-write upload port
module capture_ram #(
  parameter int AW = 13
) (
  input  logic          clk25,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);
  logic [7:0] mem [2**AW];
  // write the stored character; read returns the byte held before this edge
  always_ff @(posedge clk25) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_o <= mem[raddr_i];
  end
endmodule

// File: rtl/display_capture.sv
// display_capture: DSP/DSPCR responder with busy pacing and a ring buffer of printed text for host upload
module display_capture
  import display_pkg::*;
#(
  parameter int DEPTH_LOG2 = 13,
  parameter int BUSY_TICKS = 2
) (
  input logic               clk25,
  input logic               rst,
  display_capture_if.slave  bus
);
  localparam int BW = $clog2(BUSY_TICKS + 1);
  logic [BW-1:0]         busy_cnt_q, busy_cnt_d;
  logic [6:0]            dsp_last_q, dsp_last_d;
  logic [7:0]            dspcr_q, dspcr_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_phys;
  logic                  wrapped_q, wrapped_d, overrun_q, overrun_d, valid_q, valid_d;
  logic                  busy, wr_dsp, wr_cr, accept, store;
  logic [7:0]            filt, ram_rd;
  assign busy   = (busy_cnt_q != '0) | bus.ioctl_upload;
  assign wr_dsp = bus.cs & bus.w_en & bus.enable & (bus.address == DSP_OFS);
  assign wr_cr  = bus.cs & bus.w_en & bus.enable & (bus.address == DSPCR_OFS);
  assign filt   = filter_char(bus.din[6:0]);
  assign accept = wr_dsp & ~busy;
  assign store  = accept & filt[7] & ~bus.clear;
  assign rd_phys = wrapped_q ? wr_ptr_q + bus.upload_addr : bus.upload_addr;
  assign bus.capture_len = wrapped_q ? {1'b1, {DEPTH_LOG2{1'b0}}} : {1'b0, wr_ptr_q};
  assign bus.dout        = (bus.address == DSP_OFS) ? {busy, dsp_last_q} : dspcr_q;
  assign bus.overrun     = overrun_q;
  assign bus.upload_dout = valid_q ? ram_rd : 8'h00;
  // next-state: busy pacing, register writes, ring pointer and upload range check
  always_comb begin
    busy_cnt_d = accept ? BW'(BUSY_TICKS) :
                 (bus.enable && busy_cnt_q != '0) ? busy_cnt_q - BW'(1) : busy_cnt_q;
    dsp_last_d = accept ? bus.din[6:0] : dsp_last_q;
    dspcr_d    = wr_cr ? bus.din : dspcr_q;
    overrun_d  = bus.clear ? 1'b0 : (wr_dsp & busy) ? 1'b1 : overrun_q;
    wr_ptr_d   = bus.clear ? '0 : store ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
    wrapped_d  = bus.clear ? 1'b0 : (store && wr_ptr_q == '1) ? 1'b1 : wrapped_q;
    valid_d    = {1'b0, bus.upload_addr} < bus.capture_len;
  end
  // state registers with synchronous reset
  always_ff @(posedge clk25) begin
    if (rst) begin
      busy_cnt_q <= '0;
      dsp_last_q <= '0;
      dspcr_q    <= '0;
      overrun_q  <= 1'b0;
      wr_ptr_q   <= '0;
      wrapped_q  <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      busy_cnt_q <= busy_cnt_d;
      dsp_last_q <= dsp_last_d;
      dspcr_q    <= dspcr_d;
      overrun_q  <= overrun_d;
      wr_ptr_q   <= wr_ptr_d;
      wrapped_q  <= wrapped_d;
      valid_q    <= valid_d;
    end
  end
  capture_ram #(.AW(DEPTH_LOG2)) u_ram (
    .clk25   (clk25),
    .we_i    (store),
    .waddr_i (wr_ptr_q),
    .wdata_i ({1'b0, filt[6:0]}),
    .raddr_i (rd_phys),
    .rdata_o (ram_rd)
  );
endmodule

// File: tb/tb_display_capture.sv
// tb_display_capture: directed and random stimulus against a queue-based model of the display capture
module tb_display_capture;
  localparam int DL = 4, BT = 2, DEPTH = 16;
  logic clk25 = 1'b0;
  logic rst = 1'b0;
  always #5 clk25 = ~clk25;
  display_capture_if #(.DEPTH_LOG2(DL)) bus ();
  display_capture #(.DEPTH_LOG2(DL), .BUSY_TICKS(BT)) dut (.clk25(clk25), .rst(rst), .bus(bus));
  int checks = 0, failures = 0;
  int busy_m = 0;
  logic [6:0] last_m = '0;
  logic [7:0] dspcr_m = '0;
  bit ovr_m = 0;
  logic [7:0] cap[$];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    bit wr, wcr, bsy;
    logic [6:0] c;
    logic [7:0] ud;
    c   = bus.din[6:0];
    wr  = bus.cs && bus.w_en && bus.enable && !bus.address;
    wcr = bus.cs && bus.w_en && bus.enable && bus.address;
    bsy = busy_m != 0 || bus.ioctl_upload;
    ud  = (int'(bus.upload_addr) < cap.size()) ? cap[bus.upload_addr] : 8'h00;
    if (rst) begin
      busy_m = 0; last_m = '0; dspcr_m = '0; ovr_m = 0; ud = 8'h00;
      cap.delete();
    end else begin
      if (wr && !bsy) begin
        last_m = c;
        busy_m = BT;
        if (c == 7'h0D) cap.push_back(8'h0A);
        else if (c >= 7'h20 && c != 7'h7F) cap.push_back({1'b0, c});
        if (cap.size() > DEPTH) void'(cap.pop_front());
      end else begin
        if (wr) ovr_m = 1;
        if (bus.enable && busy_m > 0) busy_m--;
      end
      if (wcr) dspcr_m = bus.din;
      if (bus.clear) begin
        cap.delete();
        ovr_m = 0;
      end
    end
    @(posedge clk25);
    #1;
    check("dout", bus.dout, bus.address ? dspcr_m : {(busy_m != 0) || bus.ioctl_upload, last_m});
    check("len", bus.capture_len, cap.size());
    check("ovr", bus.overrun, ovr_m);
    check("udout", bus.upload_dout, ud);
  endtask
  task automatic wr_reg(input logic a, input logic [7:0] d);
    bus.cs = 1; bus.w_en = 1; bus.address = a; bus.din = d; bus.enable = 1;
    tick();
    bus.cs = 0; bus.w_en = 0; bus.address = 0;
  endtask
  task automatic settle();
    bus.enable = 1;
    for (int i = 0; i < 8 && busy_m != 0; i++) tick();
  endtask
  task automatic pulse_clear();
    bus.clear = 1;
    tick();
    bus.clear = 0;
  endtask
  task automatic up_read(input int a, input logic [7:0] e, input string tag);
    bus.upload_addr = DL'(a);
    tick();
    check(tag, bus.upload_dout, e);
  endtask
  initial begin
    bus.enable = 1; bus.cs = 0; bus.address = 0; bus.w_en = 0; bus.din = 0;
    bus.clear = 0; bus.ioctl_upload = 0; bus.upload_addr = 0;
    rst = 1;
    tick();
    rst = 0;
    check("rst_len", bus.capture_len, 0);
    check("rst_dout", bus.dout, 8'h00);
    wr_reg(0, 8'hC1); settle();
    wr_reg(0, 8'h8D); settle();
    wr_reg(0, 8'hC2); settle();
    check("len3", bus.capture_len, 3);
    bus.ioctl_upload = 1;
    up_read(0, 8'h41, "up0");
    up_read(1, 8'h0A, "up1");
    up_read(2, 8'h42, "up2");
    up_read(3, 8'h00, "up3");
    bus.ioctl_upload = 0;
    pulse_clear();
    wr_reg(0, 8'hC1);
    wr_reg(0, 8'hC2);
    check("ovr_busy", bus.overrun, 1);
    check("dsp_busy", bus.dout, 8'hC1);
    settle();
    check("len_one", bus.capture_len, 1);
    up_read(0, 8'h41, "up_one");
    pulse_clear();
    wr_reg(0, 8'h87); settle();
    wr_reg(0, 8'hFF); settle();
    check("last_7f", bus.dout, 8'h7F);
    wr_reg(0, 8'h05); settle();
    check("len_ctrl", bus.capture_len, 0);
    wr_reg(1, 8'h55);
    bus.address = 1;
    tick();
    check("dspcr", bus.dout, 8'h55);
    check("len_cr", bus.capture_len, 0);
    bus.address = 0;
    pulse_clear();
    for (int i = 0; i < 18; i++) begin
      wr_reg(0, 8'hC1 + 8'(i));
      settle();
    end
    check("len_wrap", bus.capture_len, 16);
    up_read(0, 8'h43, "wrap0");
    up_read(15, 8'h52, "wrap15");
    bus.ioctl_upload = 1;
    tick();
    check("upl_busy", bus.dout[7], 1);
    wr_reg(0, 8'hDA);
    check("upl_ovr", bus.overrun, 1);
    check("upl_len", bus.capture_len, 16);
    pulse_clear();
    check("clr_len", bus.capture_len, 0);
    check("clr_ovr", bus.overrun, 0);
    bus.ioctl_upload = 0;
    wr_reg(0, 8'hC1);
    check("pre_rst_busy", bus.dout[7], 1);
    rst = 1;
    tick();
    rst = 0;
    check("rst_busy", bus.dout[7], 0);
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom % 97) == 0;
      bus.clear = ($urandom % 40) == 0;
      bus.ioctl_upload = ($urandom % 8) == 0;
      bus.enable = ($urandom % 3) != 0;
      bus.cs = $urandom % 2;
      bus.w_en = $urandom % 2;
      bus.address = ($urandom % 4) == 0;
      bus.din = 8'($urandom);
      bus.upload_addr = DL'($urandom);
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
